if_id_skid: RTL and testbench

- Parametrised IF/ID pipeline register with valid/ready handshake and a 2-entry skid buffer. Replaces the plain always-capture IF/ID latch.
- Adds back-pressure from ID, synchronous flush for branch and exception redirects, and a pass-through fetch-exception field.
- An empty stage presents a NOP bubble to ID.
- Sits between the fetch unit / instruction ROM and the decode stage.

---
 rtl/if_id_skid_if.sv | 36 +++
 rtl/if_id_skid.sv | 85 ++++++++
 tb/tb_if_id_skid.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/if_id_skid_if.sv
// IF/ID handshake bundle shared by the fetch side, the skid stage and decode.
//   flush                        : drop every held and incoming entry this cycle
//   in_valid / in_ready          : fetch -> stage handshake
//   if_pc / if_inst / if_exc     : incoming entry fields
//   out_valid / out_ready        : stage -> decode handshake
//   id_pc / id_inst / id_exc     : registered entry presented to decode
//   occupancy                    : number of entries held (0..2)
// The master modport is the environment (fetch + decode); the slave modport is the stage itself.
interface if_id_skid_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EXC_W  = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_inst;
  logic [EXC_W-1:0]  if_exc;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [DATA_W-1:0] id_inst;
  logic [EXC_W-1:0]  id_exc;
  logic [1:0]        occupancy;

  modport master (
    output flush, in_valid, if_pc, if_inst, if_exc, out_ready,
    input  in_ready, out_valid, id_pc, id_inst, id_exc, occupancy
  );

  modport slave (
    input  flush, in_valid, if_pc, if_inst, if_exc, out_ready,
    output in_ready, out_valid, id_pc, id_inst, id_exc, occupancy
  );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with valid/ready handshake and a two-entry skid buffer.
// The main register M drives decode; the skid register S catches one entry when decode stalls,
// so in_ready depends only on registered state. An empty stage presents a NOP bubble.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : if_id_skid_if.slave handshake bundle (see interface header)
module if_id_skid #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           DATA_W   = 32,
  parameter int unsigned           EXC_W    = 4,
  parameter logic [DATA_W-1:0]     NOP_INST = '0
) (
  input  logic         clk,
  input  logic         rst,
  if_id_skid_if.slave  bus
);

  logic              m_v_q, s_v_q;
  logic [ADDR_W-1:0] m_pc_q, s_pc_q;
  logic [DATA_W-1:0] m_inst_q, s_inst_q;
  logic [EXC_W-1:0]  m_exc_q, s_exc_q;

  logic in_ready;
  logic in_fire;
  logic out_fire;

  // Only the skid valid gates acceptance: no combinational path from out_ready.
  assign in_ready = ~s_v_q & ~rst;
  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = m_v_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      m_v_q    <= 1'b0;
      m_pc_q   <= '0;
      m_inst_q <= NOP_INST;
      m_exc_q  <= '0;
      s_v_q    <= 1'b0;
      s_pc_q   <= '0;
      s_inst_q <= '0;
      s_exc_q  <= '0;
    end else if (!m_v_q) begin
      if (in_fire) begin
        m_v_q    <= 1'b1;
        m_pc_q   <= bus.if_pc;
        m_inst_q <= bus.if_inst;
        m_exc_q  <= bus.if_exc;
      end
    end else if (out_fire) begin
      if (s_v_q) begin
        // Drain the skid entry first to keep arrival order.
        m_pc_q   <= s_pc_q;
        m_inst_q <= s_inst_q;
        m_exc_q  <= s_exc_q;
        s_v_q    <= 1'b0;
      end else if (in_fire) begin
        m_pc_q   <= bus.if_pc;
        m_inst_q <= bus.if_inst;
        m_exc_q  <= bus.if_exc;
      end else begin
        m_v_q    <= 1'b0;
        m_pc_q   <= '0;
        m_inst_q <= NOP_INST;
        m_exc_q  <= '0;
      end
    end else if (!s_v_q && in_fire) begin
      s_v_q    <= 1'b1;
      s_pc_q   <= bus.if_pc;
      s_inst_q <= bus.if_inst;
      s_exc_q  <= bus.if_exc;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = m_v_q;
  assign bus.id_pc     = m_pc_q;
  assign bus.id_inst   = m_inst_q;
  assign bus.id_exc    = m_exc_q;
  assign bus.occupancy = {1'b0, m_v_q} + {1'b0, s_v_q};

  // A held skid entry always sits behind a valid main entry.
  a_skid_behind_main: assert property (@(posedge clk) disable iff (rst) !(s_v_q && !m_v_q));

endmodule

// File: tb/tb_if_id_skid.sv
module tb_if_id_skid;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned EXC_W  = 4;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic [EXC_W-1:0]  exc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_id_skid_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .EXC_W(EXC_W)) bus ();

  if_id_skid #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .EXC_W   (EXC_W),
    .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  ent_t mq[$];  // reference: FIFO of held entries, front is what decode sees

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] pc,
                       input logic [DATA_W-1:0] inst, input logic [EXC_W-1:0] exc);
    bus.in_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = inst;
    bus.if_exc   = exc;
  endtask

  // Compare outputs mid-cycle, then advance the model across the rising edge.
  task automatic step();
    ent_t exp_e;
    logic ofire, ifire;
    @(negedge clk);
    exp_e = (mq.size() > 0) ? mq[0] : ent_t'{pc: '0, inst: NOP, exc: '0};
    check_eq("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    check_eq("in_ready",  64'(bus.in_ready),  64'(!rst && mq.size() < 2));
    check_eq("occupancy", 64'(bus.occupancy), 64'(mq.size()));
    check_eq("id_pc",     64'(bus.id_pc),     64'(exp_e.pc));
    check_eq("id_inst",   64'(bus.id_inst),   64'(exp_e.inst));
    check_eq("id_exc",    64'(bus.id_exc),    64'(exp_e.exc));
    @(posedge clk);
    if (rst || bus.flush) begin
      mq.delete();
    end else begin
      ofire = (mq.size() > 0) && bus.out_ready;
      ifire = bus.in_valid && (mq.size() < 2);
      if (ofire) void'(mq.pop_front());
      if (ifire) mq.push_back(ent_t'{pc: bus.if_pc, inst: bus.if_inst, exc: bus.if_exc});
    end
    #1;
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'hAAAA, 4'h0);
    @(posedge clk);
    #1;

    // Reset with a live input: nothing captured, in_ready low during reset.
    step();
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0, '0);
    step();

    // Streaming at full rate.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'(32'h11 + i), 4'h0);
      step();
    end
    drive(1'b0, '0, '0, '0);
    step();
    step();

    // Back-pressure fills the skid register.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h4, 32'h21, 4'h0);
    step();
    drive(1'b1, 32'h8, 32'h22, 4'h0);
    step();
    drive(1'b0, '0, '0, '0);
    step();
    check_eq("bp_hold_pc", 64'(bus.id_pc), 64'h4);
    bus.out_ready = 1'b1;
    step();
    check_eq("bp_skid_pc", 64'(bus.id_pc), 64'h8);
    step();
    step();

    // Single entry drains to a bubble.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h20, 32'hDEAD, 4'h0);
    step();
    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    step();
    step();
    check_eq("drain_inst", 64'(bus.id_inst), 64'(NOP));

    // Flush while full, with a live input in the flush cycle.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h40, 32'h31, 4'h0);
    step();
    drive(1'b1, 32'h44, 32'h32, 4'h0);
    step();
    bus.flush = 1'b1;
    drive(1'b1, 32'h48, 32'h33, 4'h0);
    step();
    bus.flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    step();
    step();

    // Exception code travels through the skid register with its PC.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h7C, 32'h41, 4'h0);
    step();
    drive(1'b1, 32'h80, 32'h42, 4'h3);
    step();
    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    step();
    check_eq("exc_pc", 64'(bus.id_pc), 64'h80);
    check_eq("exc_code", 64'(bus.id_exc), 64'h3);
    drive(1'b1, 32'h84, 32'h43, 4'h0);
    step();
    drive(1'b0, '0, '0, '0);
    step();
    step();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.flush     = ($urandom_range(0, 31) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, $urandom(), $urandom(),
            EXC_W'($urandom_range(0, 15)));
      step();
    end
    rst       = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
